// File: rtl/seq_tx_11010_if.sv
// Bus bundle for the serial pattern transmitter: job request operands on one
// side, the serial stream and status on the other.
//
// Handshake: there is no ready. `valid` qualifies `outp` and the receiver
// must take one bit per cycle whenever `valid` is high. `start` is a request
// level sampled only while the transmitter is idle.
interface seq_tx_11010_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 3,
  parameter int GAP_W = 3
);
  logic             start;
  logic             use_def;
  logic [PAT_W-1:0] pat;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             outp;
  logic             valid;
  logic             busy;
  logic             done;
  logic [1:0]       state;
  logic [CNT_W-1:0] sent_count;

  modport master (
    output start, use_def, pat, reps, gap, abort,
    input  outp, valid, busy, done, state, sent_count
  );

  modport slave (
    input  start, use_def, pat, reps, gap, abort,
    output outp, valid, busy, done, state, sent_count
  );
endinterface

// File: rtl/seq_tx_11010.sv
// Serial pattern transmitter. Sends a PAT_W-bit pattern MSB first, `reps`
// times, with `gap` idle cycles between repetitions, then pulses `done`.
// Every output is a register; the FSM state is exported on `state`.
module seq_tx_11010 #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11010,
  parameter int               CNT_W   = 3,
  parameter int               GAP_W   = 3
) (
  input logic            clk,
  input logic            rst,
  seq_tx_11010_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  state_t           st;
  logic [PAT_W-1:0] lpat;
  logic [CNT_W-1:0] lreps;
  logic [GAP_W-1:0] lgap;
  logic [GAP_W-1:0] gcnt;
  // idx names the bit currently presented on outp
  logic [IDX_W-1:0] idx;
  logic             outp_r;
  logic             valid_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] sent_r;

  logic [PAT_W-1:0] src_pat;
  logic [CNT_W-1:0] sent_inc;

  assign src_pat  = bus.use_def ? PATTERN : bus.pat;
  assign sent_inc = sent_r + 1'b1;

  // Single FSM: rst beats abort beats normal sequencing; outputs are loaded
  // with the value they must show in the cycle after each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      lpat    <= '0;
      lreps   <= '0;
      lgap    <= '0;
      gcnt    <= '0;
      idx     <= '0;
      outp_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sent_r  <= '0;
    end else if (bus.abort && st != IDLE) begin
      // cancel without a done pulse; sent_r keeps the partial count
      st      <= IDLE;
      outp_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.start) begin
            lpat   <= src_pat;
            lreps  <= bus.reps;
            lgap   <= bus.gap;
            sent_r <= '0;
            busy_r <= 1'b1;
            if (bus.reps != '0) begin
              st      <= SEND;
              idx     <= IDX_MSB;
              outp_r  <= src_pat[PAT_W-1];
              valid_r <= 1'b1;
            end else begin
              st     <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        SEND: begin
          if (idx == '0) begin
            sent_r <= sent_inc;
            if (sent_inc == lreps) begin
              st      <= DONE;
              outp_r  <= 1'b0;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
            end else if (lgap != '0) begin
              st      <= GAP;
              gcnt    <= lgap;
              outp_r  <= 1'b0;
              valid_r <= 1'b0;
            end else begin
              idx    <= IDX_MSB;
              outp_r <= lpat[PAT_W-1];
            end
          end else begin
            idx    <= idx - 1'b1;
            outp_r <= lpat[idx - 1'b1];
          end
        end
        GAP: begin
          // gcnt counts the idle cycles still to show, including this one
          if (gcnt == GAP_W'(1)) begin
            st      <= SEND;
            idx     <= IDX_MSB;
            outp_r  <= lpat[PAT_W-1];
            valid_r <= 1'b1;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        DONE: begin
          st     <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.outp       = outp_r;
  assign bus.valid      = valid_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.state      = st;
  assign bus.sent_count = sent_r;

endmodule

// File: tb/tb_seq_tx_11010.sv
// Directed bench for seq_tx_11010. Each job pushes the expected per-cycle
// {done, valid, outp} triples to a queue when it is launched; the queue is
// popped and compared one entry per cycle while the job runs.
module tb_seq_tx_11010;

  localparam logic [4:0] DEF_PAT = 5'b11010;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [2:0] exp_q[$];

  seq_tx_11010_if #(.PAT_W(5), .CNT_W(3), .GAP_W(3)) bus ();

  seq_tx_11010 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected stream model: patterns MSB first, gap idles between, one done cycle
  task automatic push_job(input logic [4:0] p, input int r, input int g);
    for (int rr = 0; rr < r; rr++) begin
      for (int b = 4; b >= 0; b--) exp_q.push_back({1'b0, 1'b1, p[b]});
      if (rr < r - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(3'b000);
    end
    exp_q.push_back(3'b100);
  endtask

  task automatic check_idle(input string tag, input logic [2:0] sc);
    check({tag, ":state"}, {14'd0, bus.state}, 16'd0);
    check({tag, ":outs"}, {12'd0, bus.busy, bus.done, bus.valid, bus.outp}, 16'd0);
    check({tag, ":sent"}, {13'd0, bus.sent_count}, {13'd0, sc});
  endtask

  // called at a falling edge with the DUT idle; returns at the falling edge
  // after the DONE cycle
  task automatic run_job(input logic ud, input logic [4:0] p, input logic [2:0] r,
                         input logic [2:0] g, input string tag);
    logic [2:0] e;
    int cyc;
    bus.use_def = ud;
    bus.pat     = p;
    bus.reps    = r;
    bus.gap     = g;
    bus.start   = 1'b1;
    push_job(ud ? DEF_PAT : p, int'(r), int'(g));
    @(negedge clk);
    bus.start   = 1'b0;
    bus.pat     = 5'($urandom_range(0, 31));
    bus.use_def = ~ud;
    bus.reps    = 3'($urandom_range(0, 7));
    bus.gap     = 3'($urandom_range(0, 7));
    cyc = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ":stream"}, {13'd0, bus.done, bus.valid, bus.outp}, {13'd0, e});
      check({tag, ":busy"}, {15'd0, bus.busy}, 16'd1);
      if (e[2]) check({tag, ":sent_at_done"}, {13'd0, bus.sent_count}, {13'd0, r});
      // start mid-job and during DONE must both be ignored
      bus.start = (cyc == 2) || e[2];
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check_idle({tag, ":after"}, r);
  endtask

  initial begin
    logic [2:0] e;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.use_def = 1'b0;
    bus.pat     = '0;
    bus.reps    = '0;
    bus.gap     = '0;
    bus.abort   = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset", 3'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset", 3'd0);

    // abort while idle does nothing
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("abort_idle", 3'd0);

    run_job(1'b1, 5'd0, 3'd1, 3'd0, "def1");
    run_job(1'b0, 5'b10011, 3'd3, 3'd2, "rep_gap");
    run_job(1'b1, 5'd0, 3'd2, 3'd0, "b2b");
    run_job(1'b1, 5'd0, 3'd0, 3'd0, "zero");
    run_job(1'b1, 5'd0, 3'd7, 3'd0, "max_reps");

    // abort on cycle 8 of a reps=3 gap=1 job, together with a start
    bus.use_def = 1'b1;
    bus.reps    = 3'd3;
    bus.gap     = 3'd1;
    bus.start   = 1'b1;
    push_job(DEF_PAT, 3, 1);
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      e = exp_q.pop_front();
      check("abort:stream", {13'd0, bus.done, bus.valid, bus.outp}, {13'd0, e});
      bus.start = (cyc == 3) || (cyc == 8);
      bus.abort = (cyc == 8);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    exp_q.delete();
    check_idle("abort:after", 3'd1);
    repeat (3) begin
      @(negedge clk);
      check_idle("abort:stay_idle", 3'd1);
    end

    // reset during the gap of a reps=2 gap=3 job
    bus.use_def = 1'b0;
    bus.pat     = 5'b10110;
    bus.reps    = 3'd2;
    bus.gap     = 3'd3;
    bus.start   = 1'b1;
    push_job(5'b10110, 2, 3);
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      e = exp_q.pop_front();
      check("rst_job:stream", {13'd0, bus.done, bus.valid, bus.outp}, {13'd0, e});
      if (cyc == 7) begin
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
      end
      @(negedge clk);
    end
    exp_q.delete();
    check_idle("rst_job:reset", 3'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check_idle("rst_job:idle", 3'd0);
    run_job(1'b1, 5'd0, 3'd1, 3'd0, "after_rst");

    // one randomised job
    run_job(1'b0, 5'($urandom_range(0, 31)), 3'($urandom_range(1, 3)),
            3'($urandom_range(0, 3)), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
